imem_loader: RTL and testbench

Boot-time writer for the CPU instruction memory. Receives a byte stream over a valid/ready handshake, assembles big-endian 32-bit words and writes them to consecutive word addresses of the instruction memory's write port. Holds the CPU in reset until the image is complete. Sits between the host/serial byte source and the instruction memory, beside the monocycle core.

---
 rtl/imem_loader_if.sv | 9 +
 rtl/imem_loader.sv | 159 +++++++++++++++
 tb/tb_imem_loader.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream handshake between the host/serial byte source and imem_loader.
interface imem_loader_if;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;

   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: length-prefixed big-endian word stream -> imem write port.
// Optional trailing checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
   parameter int unsigned ADDR_W    = 10,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst,
   imem_loader_if.slave      bs,
   input  logic              reload,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_rst,
   output logic              load_done,
   output logic              load_err
);

   typedef enum logic [2:0] {
      LEN_HI,
      LEN_LO,
      DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM,
`endif
      DONE,
      ERR
   } state_t;

   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
   localparam int unsigned       CAP  = 32'd1 << (ADDR_W - 2);

   state_t            state;
   logic [7:0]        len_hi;
   logic [15:0]       words_left;
   logic [1:0]        byte_cnt;
   logic [23:0]       shift;
   logic [ADDR_W-1:0] wr_addr;
   logic              accept;
   logic [15:0]       n_val;

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0] sum;
   logic [7:0] sum_next;
   always_comb sum_next = sum + bs.in_data;
`endif

   always_comb begin
      bs.in_ready = 1'b0;
      case (state)
         LEN_HI, LEN_LO, DATA: bs.in_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
         CSUM:                 bs.in_ready = 1'b1;
`endif
         default:              bs.in_ready = 1'b0;
      endcase
   end

   always_comb accept = bs.in_valid && bs.in_ready;
   always_comb n_val  = {len_hi, bs.in_data};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= LEN_HI;
         len_hi     <= '0;
         words_left <= '0;
         byte_cnt   <= '0;
         shift      <= '0;
         wr_addr    <= BASE;
         imem_we    <= 1'b0;
         imem_addr  <= BASE;
         imem_wdata <= '0;
         cpu_rst    <= 1'b1;
         load_done  <= 1'b0;
         load_err   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum        <= '0;
`endif
      end else begin
         imem_we <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         if (accept) sum <= sum_next;
`endif
         case (state)
            LEN_HI: if (accept) begin
               len_hi <= bs.in_data;
               state  <= LEN_LO;
            end
            LEN_LO: if (accept) begin
               words_left <= n_val;
               byte_cnt   <= '0;
               if (32'(n_val) > CAP) begin
                  state    <= ERR;
                  load_err <= 1'b1;
               end else if (n_val == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state     <= CSUM;
`else
                  state     <= DONE;
                  load_done <= 1'b1;
`endif
               end else begin
                  state <= DATA;
               end
            end
            DATA: if (accept) begin
               byte_cnt <= byte_cnt + 2'd1;
               shift    <= {shift[15:0], bs.in_data};
               if (byte_cnt == 2'd3) begin
                  imem_we    <= 1'b1;
                  imem_wdata <= {shift, bs.in_data};
                  imem_addr  <= wr_addr;
                  wr_addr    <= wr_addr + ADDR_W'(4);
                  words_left <= words_left - 16'd1;
                  if (words_left == 16'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                     state     <= CSUM;
`else
                     state     <= DONE;
                     load_done <= 1'b1;
`endif
                  end
               end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: if (accept) begin
               if (sum_next == 8'h00) begin
                  state     <= DONE;
                  load_done <= 1'b1;
               end else begin
                  state    <= ERR;
                  load_err <= 1'b1;
               end
            end
`endif
            DONE, ERR: begin
               // reload wins over a pending byte: in_ready is already low here
               if (reload) begin
                  state      <= LEN_HI;
                  load_done  <= 1'b0;
                  load_err   <= 1'b0;
                  cpu_rst    <= 1'b1;
                  words_left <= '0;
                  byte_cnt   <= '0;
                  wr_addr    <= BASE;
                  imem_addr  <= BASE;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  sum        <= '0;
`endif
               end else if (state == DONE) begin
                  cpu_rst <= 1'b0;
               end
            end
            default: state <= LEN_HI;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: vector table plus scoreboard on the imem write port.
module tb_imem_loader;

   localparam int unsigned ADDR_W    = 10;
   localparam int unsigned BASE_ADDR = 0;
   localparam int unsigned CAP       = 256;
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam bit CSUM_EN = 1'b1;
`else
   localparam bit CSUM_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              reload;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              cpu_rst;
   logic              load_done;
   logic              load_err;

   imem_loader_if bs();

   imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
      .clk        (clk),
      .rst        (rst),
      .bs         (bs),
      .reload     (reload),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_rst    (cpu_rst),
      .load_done  (load_done),
      .load_err   (load_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [ADDR_W-1:0] a;
      logic [31:0]       d;
   } wr_t;

   typedef struct {
      logic [15:0] n;
      logic [31:0] base;
      bit          gaps;
      bit          bad_csum;
   } vec_t;

   wr_t         sb[$];
   int unsigned checks   = 0;
   int unsigned errors   = 0;
   int unsigned wr_count = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: every write must match the next expected {addr, data}
   always @(negedge clk) begin
      if (!rst && imem_we) begin
         wr_count++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr %0h data %0h expected no write", imem_addr, imem_wdata);
         end else begin
            wr_t e;
            e = sb.pop_front();
            check("wr_addr", 64'(imem_addr), 64'(e.a));
            check("wr_data", 64'(imem_wdata), 64'(e.d));
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int unsigned t;
      if (gaps) begin
         bs.in_valid = 1'b0;
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      bs.in_valid = 1'b1;
      bs.in_data  = b;
      t = 0;
      while (!bs.in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!bs.in_ready) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: got in_ready 0 expected 1");
      end
      @(negedge clk);
   endtask

   task automatic send_stream(input logic [15:0] n, input logic [31:0] base, input bit gaps, input bit bad);
      logic [7:0]  sum;
      logic [7:0]  c;
      logic [31:0] w;
      sum = n[15:8] + n[7:0];
      send_byte(n[15:8], gaps);
      send_byte(n[7:0], gaps);
      if (32'(n) <= CAP) begin
         for (int unsigned k = 0; k < 32'(n); k++) begin
            w = base + k * 32'h01020304;
            sb.push_back('{a: ADDR_W'(BASE_ADDR + 4 * k), d: w});
            for (int j = 3; j >= 0; j--) begin
               send_byte(w[8*j +: 8], gaps);
               sum = sum + w[8*j +: 8];
            end
         end
         c = 8'h00 - sum;
         if (bad) c = c + 8'h01;
         if (CSUM_EN) send_byte(c, gaps);
      end
      bs.in_valid = 1'b0;
   endtask

   task automatic wait_end(input string tag, input bit exp_err);
      int unsigned t;
      t = 0;
      while (!(load_done || load_err) && t < 100) begin
         @(negedge clk);
         t++;
      end
      check({tag, "_load_done"}, 64'(load_done), 64'(!exp_err));
      check({tag, "_load_err"},  64'(load_err),  64'(exp_err));
      @(negedge clk);
      check({tag, "_cpu_rst"},  64'(cpu_rst),     64'(exp_err));
      check({tag, "_in_ready"}, 64'(bs.in_ready), 64'd0);
   endtask

   task automatic pulse_reload();
      reload      = 1'b1;
      bs.in_valid = 1'b1;
      bs.in_data  = 8'h00;
      @(negedge clk);
      reload      = 1'b0;
      bs.in_valid = 1'b0;
      check("reload_cpu_rst",   64'(cpu_rst),     64'd1);
      check("reload_load_done", 64'(load_done),   64'd0);
      check("reload_load_err",  64'(load_err),    64'd0);
      check("reload_in_ready",  64'(bs.in_ready), 64'd1);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_in_ready"},   64'(bs.in_ready), 64'd1);
      check({tag, "_imem_we"},    64'(imem_we),     64'd0);
      check({tag, "_imem_addr"},  64'(imem_addr),   64'(BASE_ADDR));
      check({tag, "_imem_wdata"}, 64'(imem_wdata),  64'd0);
      check({tag, "_cpu_rst"},    64'(cpu_rst),     64'd1);
      check({tag, "_load_done"},  64'(load_done),   64'd0);
      check({tag, "_load_err"},   64'(load_err),    64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[8];
      bit   len_err;
      bit   exp_err;

      vecs[0] = '{n: 16'd3,      base: 32'h11223344, gaps: 1'b1, bad_csum: 1'b0};
      vecs[1] = '{n: 16'd0,      base: 32'h00000000, gaps: 1'b0, bad_csum: 1'b0};
      vecs[2] = '{n: 16'h0101,   base: 32'h00000000, gaps: 1'b0, bad_csum: 1'b0};
      vecs[3] = '{n: 16'd256,    base: 32'h0F0E0D0C, gaps: 1'b0, bad_csum: 1'b0};
      vecs[4] = '{n: 16'd257,    base: 32'h00000000, gaps: 1'b0, bad_csum: 1'b0};
      vecs[5] = '{n: 16'd1,      base: 32'hAABBCCDD, gaps: 1'b0, bad_csum: 1'b0};
      vecs[6] = '{n: 16'd1,      base: 32'hAABBCCDD, gaps: 1'b0, bad_csum: 1'b1};
      vecs[7] = '{n: 16'd2,      base: 32'hCAFEF00D, gaps: 1'b1, bad_csum: 1'b0};

      rst         = 1'b1;
      reload      = 1'b0;
      bs.in_valid = 1'b0;
      bs.in_data  = 8'h00;
      repeat (2) @(negedge clk);
      check_reset("por");
      rst = 1'b0;
      @(negedge clk);

      // Single word: write pulse and load_done on the same cycle, cpu_rst one later
      send_stream(16'd1, 32'h12345678, 1'b0, 1'b0);
      if (!CSUM_EN) begin
         check("first_imem_we",   64'(imem_we),   64'd1);
         check("first_load_done", 64'(load_done), 64'd1);
         check("first_cpu_rst",   64'(cpu_rst),   64'd1);
      end
      wait_end("first", 1'b0);
      check("first_wr_count", 64'(wr_count), 64'd1);

      for (int i = 0; i < 8; i++) begin
         pulse_reload();
         wr_count = 0;
         len_err  = 32'(vecs[i].n) > CAP;
         exp_err  = len_err || (CSUM_EN && vecs[i].bad_csum);
         send_stream(vecs[i].n, vecs[i].base, vecs[i].gaps, vecs[i].bad_csum);
         wait_end($sformatf("vec%0d", i), exp_err);
         check($sformatf("vec%0d_wr_count", i), 64'(wr_count), len_err ? 64'd0 : 64'(vecs[i].n));
         check($sformatf("vec%0d_sb_empty", i), 64'(sb.size()), 64'd0);
      end

      // Reset after the 2nd data byte aborts at once
      pulse_reload();
      send_byte(8'h00, 1'b0);
      send_byte(8'h02, 1'b0);
      send_byte(8'h12, 1'b0);
      send_byte(8'h34, 1'b0);
      bs.in_valid = 1'b0;
      rst = 1'b1;
      #1;
      check_reset("midrst");
      @(negedge clk);
      rst = 1'b0;
      sb.delete();
      wr_count = 0;
      @(negedge clk);
      send_stream(16'd2, 32'hDEADBEEF, 1'b0, 1'b0);
      wait_end("after_rst", 1'b0);
      check("after_rst_wr_count", 64'(wr_count), 64'd2);

      check("final_sb_empty", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
